// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared ezRISC opcodes, ALU function codes, IR field positions and sequencer types
package cpu_pkg;

    localparam int OPC_MSB = 31;
    localparam int OPC_LSB = 27;
    localparam int RA_MSB  = 26;
    localparam int RA_LSB  = 23;
    localparam int RB_MSB  = 22;
    localparam int RB_LSB  = 19;
    localparam int RC_MSB  = 18;
    localparam int RC_LSB  = 15;

    localparam logic [4:0] OP_ADD  = 5'b00011;
    localparam logic [4:0] OP_SUB  = 5'b00100;
    localparam logic [4:0] OP_SHR  = 5'b00101;
    localparam logic [4:0] OP_SHL  = 5'b00110;
    localparam logic [4:0] OP_ROR  = 5'b00111;
    localparam logic [4:0] OP_ROL  = 5'b01000;
    localparam logic [4:0] OP_AND  = 5'b01001;
    localparam logic [4:0] OP_OR   = 5'b01010;
    localparam logic [4:0] OP_MUL  = 5'b01111;
    localparam logic [4:0] OP_DIV  = 5'b10000;
    localparam logic [4:0] OP_NEG  = 5'b10001;
    localparam logic [4:0] OP_NOT  = 5'b10010;
    localparam logic [4:0] OP_NOP  = 5'b11010;
    localparam logic [4:0] OP_HALT = 5'b11011;

    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0011;
    localparam logic [3:0] ALU_SHR = 4'b0100;
    localparam logic [3:0] ALU_SHL = 4'b0101;
    localparam logic [3:0] ALU_ROR = 4'b0110;
    localparam logic [3:0] ALU_ROL = 4'b0111;
    localparam logic [3:0] ALU_MUL = 4'b1000;
    localparam logic [3:0] ALU_DIV = 4'b1001;
    localparam logic [3:0] ALU_NEG = 4'b1010;
    localparam logic [3:0] ALU_NOT = 4'b1011;

    typedef enum logic [3:0] {
        ST_RESET,
        ST_T0,
        ST_T1,
        ST_T2,
        ST_T3,
        ST_T4,
        ST_T5,
        ST_T6,
        ST_HALT
    } cu_state_e;

    typedef enum logic [2:0] {
        CLS_NOP,
        CLS_BINARY,
        CLS_UNARY,
        CLS_MULDIV,
        CLS_HALT
    } instr_class_e;

    function automatic logic [3:0] opc_to_alu(input logic [4:0] opc);
        logic [3:0] f;
        f = ALU_AND;
        case (opc)
            OP_ADD:  f = ALU_ADD;
            OP_SUB:  f = ALU_SUB;
            OP_SHR:  f = ALU_SHR;
            OP_SHL:  f = ALU_SHL;
            OP_ROR:  f = ALU_ROR;
            OP_ROL:  f = ALU_ROL;
            OP_AND:  f = ALU_AND;
            OP_OR:   f = ALU_OR;
            OP_MUL:  f = ALU_MUL;
            OP_DIV:  f = ALU_DIV;
            OP_NEG:  f = ALU_NEG;
            OP_NOT:  f = ALU_NOT;
            default: f = ALU_AND;
        endcase
        return f;
    endfunction

endpackage

// File: rtl/reg_sel_decoder.sv
// rtl/reg_sel_decoder.sv - 4-bit register index plus enable to 16-bit one-hot select
module reg_sel_decoder (
    input  logic [3:0]  idx,
    input  logic        en,
    output logic [15:0] onehot
);

    assign onehot = en ? (16'h0001 << idx) : 16'h0000;

endmodule

// File: rtl/control_unit.sv
// rtl/control_unit.sv - ezRISC hardwired control sequencer; CU_MULDIV_EN adds the mul/div T3-T6 sequence
module control_unit
    import cpu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] ir,
    input  logic             stop,
    output logic [15:0]      gpr_in,
    output logic [15:0]      gpr_out,
    output logic             hi_in,
    output logic             lo_in,
    output logic             pc_in,
    output logic             pc_out,
    output logic             ir_in,
    output logic             z_in,
    output logic             z_high_out,
    output logic             z_low_out,
    output logic             y_in,
    output logic             mar_in,
    output logic             mdr_in,
    output logic             mdr_out,
    output logic             read,
    output logic             inc_pc,
    output logic [3:0]       alu_op,
    output logic             run
);

    cu_state_e    state_q, state_d;
    logic         stop_pend_q, stop_pend_d;
    instr_class_e cls;
    cu_state_e    done_state;

    logic [4:0] opc;
    logic [3:0] ra, rb, rc;
    logic       ir_unused;

    logic       gin_en, gout_en;
    logic [3:0] gin_idx, gout_idx;

    assign opc = ir[OPC_MSB:OPC_LSB];
    assign ra  = ir[RA_MSB:RA_LSB];
    assign rb  = ir[RB_MSB:RB_LSB];
    assign rc  = ir[RC_MSB:RC_LSB];
    assign ir_unused = ^ir[RC_LSB-1:0];

    always_comb begin
        cls = CLS_NOP;
        case (opc)
            OP_ADD, OP_SUB, OP_SHR, OP_SHL,
            OP_ROR, OP_ROL, OP_AND, OP_OR: cls = CLS_BINARY;
            OP_NEG, OP_NOT:                cls = CLS_UNARY;
`ifdef CU_MULDIV_EN
            OP_MUL, OP_DIV:                cls = CLS_MULDIV;
`endif
            OP_HALT:                       cls = CLS_HALT;
            OP_NOP:                        cls = CLS_NOP;
            default:                       cls = CLS_NOP;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_RESET;
            stop_pend_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            stop_pend_q <= stop_pend_d;
        end
    end

    // A stop arriving on the same edge that ends the instruction still counts.
    always_comb begin
        state_d     = state_q;
        stop_pend_d = stop_pend_q | stop;
        done_state  = (stop_pend_q | stop) ? ST_HALT : ST_T0;
        case (state_q)
            ST_RESET: state_d = ST_T0;
            ST_T0:    state_d = ST_T1;
            ST_T1:    state_d = ST_T2;
            ST_T2:    state_d = ST_T3;
            ST_T3: begin
                case (cls)
                    CLS_BINARY, CLS_UNARY, CLS_MULDIV: state_d = ST_T4;
                    CLS_HALT:                          state_d = ST_HALT;
                    default:                           state_d = done_state;
                endcase
            end
            ST_T4: begin
                if (cls == CLS_BINARY || cls == CLS_MULDIV) state_d = ST_T5;
                else                                        state_d = done_state;
            end
            ST_T5: begin
`ifdef CU_MULDIV_EN
                if (cls == CLS_MULDIV) state_d = ST_T6;
                else                   state_d = done_state;
`else
                state_d = done_state;
`endif
            end
            ST_T6:    state_d = done_state;
            ST_HALT:  state_d = ST_HALT;
            default:  state_d = ST_RESET;
        endcase
    end

    always_comb begin
        gin_en     = 1'b0;
        gin_idx    = 4'd0;
        gout_en    = 1'b0;
        gout_idx   = 4'd0;
        hi_in      = 1'b0;
        lo_in      = 1'b0;
        pc_in      = 1'b0;
        pc_out     = 1'b0;
        ir_in      = 1'b0;
        z_in       = 1'b0;
        z_high_out = 1'b0;
        z_low_out  = 1'b0;
        y_in       = 1'b0;
        mar_in     = 1'b0;
        mdr_in     = 1'b0;
        mdr_out    = 1'b0;
        read       = 1'b0;
        inc_pc     = 1'b0;
        alu_op     = ALU_AND;
        run        = (state_q != ST_RESET) && (state_q != ST_HALT);
        case (state_q)
            ST_T0: begin
                pc_out = 1'b1;
                mar_in = 1'b1;
                inc_pc = 1'b1;
                z_in   = 1'b1;
                alu_op = ALU_ADD;
            end
            ST_T1: begin
                z_low_out = 1'b1;
                pc_in     = 1'b1;
                read      = 1'b1;
                mdr_in    = 1'b1;
            end
            ST_T2: begin
                mdr_out = 1'b1;
                ir_in   = 1'b1;
            end
            ST_T3: begin
                if (cls == CLS_BINARY || cls == CLS_MULDIV) begin
                    gout_en  = 1'b1;
                    gout_idx = rb;
                    y_in     = 1'b1;
                end else if (cls == CLS_UNARY) begin
                    gout_en  = 1'b1;
                    gout_idx = rb;
                    alu_op   = opc_to_alu(opc);
                    z_in     = 1'b1;
                end
            end
            ST_T4: begin
                if (cls == CLS_BINARY || cls == CLS_MULDIV) begin
                    gout_en  = 1'b1;
                    gout_idx = rc;
                    alu_op   = opc_to_alu(opc);
                    z_in     = 1'b1;
                end else if (cls == CLS_UNARY) begin
                    z_low_out = 1'b1;
                    gin_en    = 1'b1;
                    gin_idx   = ra;
                end
            end
            ST_T5: begin
                if (cls == CLS_BINARY) begin
                    z_low_out = 1'b1;
                    gin_en    = 1'b1;
                    gin_idx   = ra;
                end
`ifdef CU_MULDIV_EN
                else if (cls == CLS_MULDIV) begin
                    z_low_out = 1'b1;
                    lo_in     = 1'b1;
                end
`endif
            end
`ifdef CU_MULDIV_EN
            ST_T6: begin
                z_high_out = 1'b1;
                hi_in      = 1'b1;
            end
`endif
            default: ;
        endcase
    end

    reg_sel_decoder u_gpr_in_dec (
        .idx    (gin_idx),
        .en     (gin_en),
        .onehot (gpr_in)
    );

    reg_sel_decoder u_gpr_out_dec (
        .idx    (gout_idx),
        .en     (gout_en),
        .onehot (gpr_out)
    );

endmodule

// File: tb/tb_control_unit.sv
// tb/tb_control_unit.sv - scoreboard bench for control_unit; honours CU_MULDIV_EN
module tb_control_unit;

    localparam logic [13:0] B_HI_IN   = 14'h2000;
    localparam logic [13:0] B_LO_IN   = 14'h1000;
    localparam logic [13:0] B_PC_IN   = 14'h0800;
    localparam logic [13:0] B_PC_OUT  = 14'h0400;
    localparam logic [13:0] B_IR_IN   = 14'h0200;
    localparam logic [13:0] B_Z_IN    = 14'h0100;
    localparam logic [13:0] B_ZH_OUT  = 14'h0080;
    localparam logic [13:0] B_ZL_OUT  = 14'h0040;
    localparam logic [13:0] B_Y_IN    = 14'h0020;
    localparam logic [13:0] B_MAR_IN  = 14'h0010;
    localparam logic [13:0] B_MDR_IN  = 14'h0008;
    localparam logic [13:0] B_MDR_OUT = 14'h0004;
    localparam logic [13:0] B_READ    = 14'h0002;
    localparam logic [13:0] B_INC_PC  = 14'h0001;

    logic        clk;
    logic        reset_n;
    logic [31:0] ir;
    logic        stop;
    logic [15:0] gpr_in, gpr_out;
    logic        hi_in, lo_in, pc_in, pc_out, ir_in, z_in, z_high_out, z_low_out;
    logic        y_in, mar_in, mdr_in, mdr_out, read, inc_pc, run;
    logic [3:0]  alu_op;

    control_unit #(.WIDTH(32)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .ir         (ir),
        .stop       (stop),
        .gpr_in     (gpr_in),
        .gpr_out    (gpr_out),
        .hi_in      (hi_in),
        .lo_in      (lo_in),
        .pc_in      (pc_in),
        .pc_out     (pc_out),
        .ir_in      (ir_in),
        .z_in       (z_in),
        .z_high_out (z_high_out),
        .z_low_out  (z_low_out),
        .y_in       (y_in),
        .mar_in     (mar_in),
        .mdr_in     (mdr_in),
        .mdr_out    (mdr_out),
        .read       (read),
        .inc_pc     (inc_pc),
        .alu_op     (alu_op),
        .run        (run)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [50:0] obs;
    assign obs = {run, gpr_in, gpr_out, hi_in, lo_in, pc_in, pc_out, ir_in, z_in,
                  z_high_out, z_low_out, y_in, mar_in, mdr_in, mdr_out, read, inc_pc, alu_op};

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [50:0] exp_q[$];
    string       tag_q[$];
    logic [50:0] mon_exp;
    string       mon_tag;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] want);
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, want);
        end
    endtask

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            mon_exp = exp_q.pop_front();
            mon_tag = tag_q.pop_front();
            check_eq(mon_tag, {13'd0, obs}, {13'd0, mon_exp});
        end
    end

    function automatic logic [50:0] ev(input bit r, input logic [15:0] gi, input logic [15:0] go,
                                       input logic [13:0] s, input logic [3:0] a);
        return {r, gi, go, s, a};
    endfunction

    function automatic logic [3:0] exp_alu(input logic [4:0] opc);
        case (opc)
            5'b00011: return 4'b0010;
            5'b00100: return 4'b0011;
            5'b00101: return 4'b0100;
            5'b00110: return 4'b0101;
            5'b00111: return 4'b0110;
            5'b01000: return 4'b0111;
            5'b01001: return 4'b0000;
            5'b01010: return 4'b0001;
            5'b01111: return 4'b1000;
            5'b10000: return 4'b1001;
            5'b10001: return 4'b1010;
            5'b10010: return 4'b1011;
            default:  return 4'b0000;
        endcase
    endfunction

    // 0 binary, 1 unary, 2 mul/div, 3 nop/illegal, 4 halt
    function automatic int exp_cls(input logic [4:0] opc);
        if (opc >= 5'b00011 && opc <= 5'b01010) return 0;
        if (opc == 5'b10001 || opc == 5'b10010) return 1;
`ifdef CU_MULDIV_EN
        if (opc == 5'b01111 || opc == 5'b10000) return 2;
`endif
        if (opc == 5'b11011) return 4;
        return 3;
    endfunction

    task automatic step(input string tag, input logic [50:0] e);
        exp_q.push_back(e);
        tag_q.push_back(tag);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input int cycles);
        reset_n = 1'b0;
        for (int i = 0; i < cycles; i++) step("reset", '0);
        reset_n = 1'b1;
        step("reset_release", '0);
    endtask

    task automatic fetch(input logic [31:0] instr, input bit stop_t1);
        ir = instr;
        step("t0", ev(1, 0, 0, B_PC_OUT | B_MAR_IN | B_INC_PC | B_Z_IN, 4'b0010));
        if (stop_t1) stop = 1'b1;
        step("t1", ev(1, 0, 0, B_ZL_OUT | B_PC_IN | B_READ | B_MDR_IN, 4'b0000));
        stop = 1'b0;
        step("t2", ev(1, 0, 0, B_MDR_OUT | B_IR_IN, 4'b0000));
    endtask

    task automatic exec(input logic [31:0] instr, input bit stop_t1, output bit halted);
        logic [4:0]  opc;
        logic [15:0] ra1, rb1, rc1;
        logic [3:0]  a;
        int          c;
        opc = instr[31:27];
        ra1 = 16'h0001 << instr[26:23];
        rb1 = 16'h0001 << instr[22:19];
        rc1 = 16'h0001 << instr[18:15];
        a   = exp_alu(opc);
        c   = exp_cls(opc);
        fetch(instr, stop_t1);
        case (c)
            0: begin
                step("bin_t3", ev(1, 0, rb1, B_Y_IN, 4'b0000));
                step("bin_t4", ev(1, 0, rc1, B_Z_IN, a));
                step("bin_t5", ev(1, ra1, 0, B_ZL_OUT, 4'b0000));
            end
            1: begin
                step("un_t3", ev(1, 0, rb1, B_Z_IN, a));
                step("un_t4", ev(1, ra1, 0, B_ZL_OUT, 4'b0000));
            end
            2: begin
                step("md_t3", ev(1, 0, rb1, B_Y_IN, 4'b0000));
                step("md_t4", ev(1, 0, rc1, B_Z_IN, a));
                step("md_t5", ev(1, 0, 0, B_ZL_OUT | B_LO_IN, 4'b0000));
                step("md_t6", ev(1, 0, 0, B_ZH_OUT | B_HI_IN, 4'b0000));
            end
            default: step("nop_t3", ev(1, 0, 0, 14'h0, 4'b0000));
        endcase
        halted = stop_t1 || (c == 4);
    endtask

    task automatic run_one(input logic [31:0] instr, input bit stop_t1);
        bit h;
        exec(instr, stop_t1, h);
        if (h) begin
            for (int i = 0; i < 3; i++) step("halt", '0);
            do_reset(2);
        end
    endtask

    initial begin
        reset_n = 1'b0;
        ir      = '0;
        stop    = 1'b0;
        @(posedge clk);
        #1;
        do_reset(3);

        run_one(32'h52920000, 1'b0);
        run_one(32'h18918000, 1'b0);
        run_one(32'h8B380000, 1'b0);
        run_one(32'h93380000, 1'b0);
        run_one(32'h781A0000, 1'b0);
        run_one(32'h80118000, 1'b0);
        run_one(32'hD0000000, 1'b0);
        run_one(32'h00000000, 1'b0);
        run_one(32'hF8000000, 1'b0);

        for (int k = 0; k < 10; k++) begin
            logic [31:0] w;
            w = {5'($urandom_range(3, 10)), 4'($urandom), 4'($urandom), 4'($urandom), 15'($urandom)};
            run_one(w, 1'b0);
        end

        // abort add R1,R2,R3 just as T5 would write R1
        fetch(32'h18918000, 1'b0);
        step("abort_t3", ev(1, 0, 16'h0004, B_Y_IN, 4'b0000));
        step("abort_t4", ev(1, 0, 16'h0008, B_Z_IN, 4'b0010));
        do_reset(2);
        run_one(32'hD0000000, 1'b0);

        run_one(32'h52920000, 1'b1);
        run_one(32'hD0000000, 1'b0);
        run_one(32'hD8000000, 1'b0);
        run_one(32'h18918000, 1'b0);

        @(negedge clk);
        #1;
        check_eq("scoreboard_drained", 64'(exp_q.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
